// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// MemWbPipe: MEM -> WB pipeline register for a Y86-style 5-stage pipeline.
//
// This module takes the instruction currently in MEM and decides which
// registers it will write (dstE / dstM) and with which data (valE / valM).
// It also folds a data-memory fault into the instruction status and
// registers everything for the write-back stage. Once a non-AOK instruction
// reaches WB the pipe freezes ("halted") until reset. It also keeps a
// saturating count of retired AOK instructions.
//
// Ports
//   clk           : single clock, all state changes on the rising edge
//   rst           : asynchronous, active-high reset
//   stall         : hold the current WB contents
//   bubble        : load a NOP bubble instead of the MEM contents
//   mem_icode     : instruction code of the instruction in MEM
//   mem_stat      : status carried from earlier stages (AOK/HLT/ADR/INS)
//   mem_dmem_err  : data-memory access fault raised in MEM this cycle
//   mem_cnd       : condition result, used by CMOVXX
//   mem_rA/mem_rB : register specifiers of the MEM instruction
//   mem_valE      : ALU result from MEM
//   mem_valM      : memory read data from MEM
//   wb_valE/valM  : registered write-back data
//   wb_dstE/dstM  : registered destination registers
//   wb_weE/weM    : register-file write enables
//   wb_stat       : registered status of the WB instruction
//   halted        : sticky flag, WB holds a non-AOK instruction
//   retired       : saturating count of AOK non-bubble loads into WB
// ---------------------------------------------------------------------------
module mem_wb_pipe #(
    parameter int          DATA_W = 32,
    parameter int          CNT_W  = 16,
    parameter logic [3:0]  RNONE  = 4'hf,
    parameter logic [3:0]  RESP   = 4'h4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic [3:0]        mem_icode,
    input  logic [2:0]        mem_stat,
    input  logic              mem_dmem_err,
    input  logic              mem_cnd,
    input  logic [3:0]        mem_rA,
    input  logic [3:0]        mem_rB,
    input  logic [DATA_W-1:0] mem_valE,
    input  logic [DATA_W-1:0] mem_valM,
    output logic [DATA_W-1:0] wb_valE,
    output logic [DATA_W-1:0] wb_valM,
    output logic [3:0]        wb_dstE,
    output logic [3:0]        wb_dstM,
    output logic              wb_weE,
    output logic              wb_weM,
    output logic [2:0]        wb_stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    // Status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 4'd4;

    // Registered WB state
    logic [DATA_W-1:0] r_valE;
    logic [DATA_W-1:0] r_valM;
    logic [3:0]        r_dstE;
    logic [3:0]        r_dstM;
    logic              r_weE;
    logic              r_weM;
    logic [2:0]        r_stat;
    logic              r_halted;
    logic [CNT_W-1:0]  r_retired;

    // Next-state values derived from the MEM instruction
    logic [3:0]        w_dstE;
    logic [3:0]        w_dstM;
    logic [2:0]        w_stat;
    logic              w_statAok;
    logic              w_weE;
    logic              w_weM;
    logic              w_retiredMax;
    logic [CNT_W-1:0]  w_retiredInc;

    // Destination selection. A CMOVXX whose condition failed behaves like
    // a NOP for write-back, so its dstE collapses to RNONE here, not in WB.
    always_comb begin
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (mem_icode)
            I_CMOVXX:                        w_dstE = mem_cnd ? mem_rB : RNONE;
            I_IRMOVL, I_OPL:                 w_dstE = mem_rB;
            I_CALL, I_RET, I_PUSHL, I_POPL:  w_dstE = RESP;
            default:                         w_dstE = RNONE;
        endcase
        case (mem_icode)
            I_MRMOVL, I_POPL:                w_dstM = mem_rA;
            default:                         w_dstM = RNONE;
        endcase
    end

    // A memory fault only turns an otherwise healthy instruction into ADR.
    // An earlier fault (HLT/INS/ADR) keeps its original code because it is
    // the older and more precise cause.
    always_comb begin
        w_stat    = mem_stat;
        if (mem_dmem_err && (mem_stat == S_AOK)) begin
            w_stat = S_ADR;
        end
        w_statAok = (w_stat == S_AOK);
        // Faulting instructions must never update architectural state.
        w_weE     = (w_dstE != RNONE) && w_statAok;
        w_weM     = (w_dstM != RNONE) && w_statAok;
    end

    // Saturating retire counter helpers
    assign w_retiredMax = &r_retired;
    assign w_retiredInc = r_retired + {{(CNT_W-1){1'b0}}, 1'b1};

    // Pipeline register update. The priority order is halted, then stall,
    // then bubble, then a normal load. Once halted the register contents
    // stay visible for debug, but the write enables are forced low so
    // nothing can be written repeatedly. A stall keeps the enables as they
    // are: repeating the same register-file write is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valE    <= '0;
            r_valM    <= '0;
            r_dstE    <= RNONE;
            r_dstM    <= RNONE;
            r_weE     <= 1'b0;
            r_weM     <= 1'b0;
            r_stat    <= S_AOK;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else if (r_halted) begin
            r_weE     <= 1'b0;
            r_weM     <= 1'b0;
        end else if (stall) begin
            r_valE    <= r_valE;
        end else if (bubble) begin
            r_valE    <= '0;
            r_valM    <= '0;
            r_dstE    <= RNONE;
            r_dstM    <= RNONE;
            r_weE     <= 1'b0;
            r_weM     <= 1'b0;
            r_stat    <= S_AOK;
        end else begin
            r_valE    <= mem_valE;
            r_valM    <= mem_valM;
            r_dstE    <= w_dstE;
            r_dstM    <= w_dstM;
            r_weE     <= w_weE;
            r_weM     <= w_weM;
            r_stat    <= w_stat;
            if (!w_statAok) begin
                r_halted <= 1'b1;
            end else if (!w_retiredMax) begin
                r_retired <= w_retiredInc;
            end
        end
    end

    assign wb_valE = r_valE;
    assign wb_valM = r_valM;
    assign wb_dstE = r_dstE;
    assign wb_dstM = r_dstM;
    assign wb_weE  = r_weE;
    assign wb_weM  = r_weM;
    assign wb_stat = r_stat;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule
